mor1kx_cache_bus_arbiter: RTL and testbench

- Shares one memory bus port between the dcache memory side (master 0) and the icache memory side (master 1).
- Grant is held for a whole transaction or burst, for as long as the granted master keeps its req high. This keeps a multi-beat cache refill atomic.
- Round-robin on contention; downstream ack/err are routed only to the granted master.
- Sits between the two cache controllers and the bus bridge (Wishbone/AVALON adapter).

---
 rtl/mor1kx_cache_bus_arbiter_pkg.sv | 12 +
 rtl/mor1kx_cache_bus_arbiter_timeout.sv | 35 +++
 rtl/mor1kx_cache_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_mor1kx_cache_bus_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_cache_bus_arbiter_pkg.sv
// Shared types for the cache bus arbiter: one-hot FSM encoding and bus widths.
package mor1kx_cache_bus_arbiter_pkg;

  localparam int unsigned BselWidth = 4;

  typedef enum logic [2:0] {
    ArbIdle = 3'b001,
    ArbGnt0 = 3'b010,
    ArbGnt1 = 3'b100
  } arb_state_e;

endpackage

// File: rtl/mor1kx_cache_bus_arbiter_timeout.sv
// Watchdog counter for a granted transaction: clears on clr_i, counts on inc_i and
// pulses expire_o on the cycle that would make the count reach TIMEOUT_CYCLES.
module mor1kx_cache_bus_arbiter_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  assign expire_o = inc_i && (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mor1kx_cache_bus_arbiter.sv
// Two-master round-robin arbiter sharing one memory bus between dcache (m0) and icache (m1).
// Define MOR1KX_CACHE_ARB_TIMEOUT_EN to add a no-ack watchdog that forces an error.
module mor1kx_cache_bus_arbiter
  import mor1kx_cache_bus_arbiter_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES       = 255,
  parameter int unsigned TIMEOUT_WIDTH        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            m0_req_i,
  input  logic                            m0_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] m0_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] m0_dat_i,
  input  logic [BselWidth-1:0]            m0_bsel_i,
  output logic                            m0_ack_o,
  output logic                            m0_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] m0_dat_o,
  input  logic                            m1_req_i,
  input  logic                            m1_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] m1_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] m1_dat_i,
  input  logic [BselWidth-1:0]            m1_bsel_i,
  output logic                            m1_ack_o,
  output logic                            m1_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] m1_dat_o,
  output logic                            bus_req_o,
  output logic                            bus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_o,
  output logic [BselWidth-1:0]            bus_bsel_o,
  input  logic                            bus_ack_i,
  input  logic                            bus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (64'd1 << TIMEOUT_WIDTH)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..2**TIMEOUT_WIDTH-1");
  end

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       gnt0, gnt1, req_raw, expire, err_fire;

  assign gnt0    = (state_q == ArbGnt0);
  assign gnt1    = (state_q == ArbGnt1);
  assign req_raw = (gnt0 & m0_req_i) | (gnt1 & m1_req_i);

`ifdef MOR1KX_CACHE_ARB_TIMEOUT_EN
  mor1kx_cache_bus_arbiter_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus_ack_i | ((state_d != state_q) & (state_d != ArbIdle))),
    .inc_i   (req_raw & ~bus_ack_i),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign err_fire = bus_err_i | expire;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ArbIdle: begin
        if (m0_req_i && m1_req_i) begin
          state_d = last_grant_q ? ArbGnt0 : ArbGnt1;
        end else if (m0_req_i) begin
          state_d = ArbGnt0;
        end else if (m1_req_i) begin
          state_d = ArbGnt1;
        end
      end
      ArbGnt0: begin
        // An error ends the transaction even if the master still holds req.
        if (err_fire) begin
          state_d      = ArbIdle;
          last_grant_d = 1'b0;
        end else if (!m0_req_i) begin
          state_d      = m1_req_i ? ArbGnt1 : ArbIdle;
          last_grant_d = 1'b0;
        end
      end
      ArbGnt1: begin
        if (err_fire) begin
          state_d      = ArbIdle;
          last_grant_d = 1'b1;
        end else if (!m1_req_i) begin
          state_d      = m0_req_i ? ArbGnt0 : ArbIdle;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ArbIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    bus_req_o  = 1'b0;
    bus_we_o   = 1'b0;
    bus_adr_o  = '0;
    bus_dat_o  = '0;
    bus_bsel_o = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    if (gnt0) begin
      bus_req_o  = req_raw & ~expire;
      bus_we_o   = m0_we_i;
      bus_adr_o  = m0_adr_i;
      bus_dat_o  = m0_dat_i;
      bus_bsel_o = m0_bsel_i;
      m0_ack_o   = bus_ack_i;
      m0_err_o   = err_fire;
    end else if (gnt1) begin
      bus_req_o  = req_raw & ~expire;
      bus_we_o   = m1_we_i;
      bus_adr_o  = m1_adr_i;
      bus_dat_o  = m1_dat_i;
      bus_bsel_o = m1_bsel_i;
      m1_ack_o   = bus_ack_i;
      m1_err_o   = err_fire;
    end
  end

  assign m0_dat_o = bus_dat_i;
  assign m1_dat_o = bus_dat_i;

endmodule

// File: tb/tb_mor1kx_cache_bus_arbiter.sv
// Scoreboard bench for the cache bus arbiter: each cycle pushes the expected outputs for the
// driven stimulus and pops them when the outputs are sampled at the falling edge.
module tb_mor1kx_cache_bus_arbiter;

  localparam logic [31:0] Adr0 = 32'h0000_0100;
  localparam logic [31:0] Adr1 = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o;
  logic [3:0]  bus_bsel_o;
  logic        bus_ack_i = 1'b0, bus_err_i = 1'b0;
  logic [31:0] bus_dat_i = '0;

  typedef struct {
    string       tag;
    logic        req;
    logic [31:0] adr;
    logic        a0, a1, e0, e1;
    logic [31:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mor1kx_cache_bus_arbiter #(
    .OPTION_OPERAND_WIDTH(32),
    .TIMEOUT_CYCLES      (4),
    .TIMEOUT_WIDTH       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req_i  (m0_req_i),
    .m0_we_i   (1'b1),
    .m0_adr_i  (Adr0),
    .m0_dat_i  (32'hD0D0_0000),
    .m0_bsel_i (4'hF),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m0_dat_o  (m0_dat_o),
    .m1_req_i  (m1_req_i),
    .m1_we_i   (1'b0),
    .m1_adr_i  (Adr1),
    .m1_dat_i  (32'hD1D1_1111),
    .m1_bsel_i (4'h3),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .m1_dat_o  (m1_dat_o),
    .bus_req_o (bus_req_o),
    .bus_we_o  (bus_we_o),
    .bus_adr_o (bus_adr_o),
    .bus_dat_o (bus_dat_o),
    .bus_bsel_o(bus_bsel_o),
    .bus_ack_i (bus_ack_i),
    .bus_err_i (bus_err_i),
    .bus_dat_i (bus_dat_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs, record the expected outputs, then sample and compare.
  task automatic cyc(input logic r, input logic q0, input logic q1, input logic ack,
                     input logic err, input logic e_req, input logic [31:0] e_adr,
                     input logic e_a0, input logic e_a1, input logic e_e0, input logic e_e1,
                     input string tag);
    exp_t e;
    exp_t o;
    logic [31:0] d;
    @(posedge clk);
    #1;
    d         = $urandom;
    rst       = r;
    m0_req_i  = q0;
    m1_req_i  = q1;
    bus_ack_i = ack;
    bus_err_i = err;
    bus_dat_i = d;
    e = '{tag: tag, req: e_req, adr: e_adr, a0: e_a0, a1: e_a1, e0: e_e0, e1: e_e1, dat: d};
    sb_q.push_back(e);
    @(negedge clk);
    o = sb_q.pop_front();
    check_eq({o.tag, ".req"}, {31'd0, bus_req_o}, {31'd0, o.req});
    check_eq({o.tag, ".adr"}, bus_adr_o, o.adr);
    check_eq({o.tag, ".ack0"}, {31'd0, m0_ack_o}, {31'd0, o.a0});
    check_eq({o.tag, ".ack1"}, {31'd0, m1_ack_o}, {31'd0, o.a1});
    check_eq({o.tag, ".err0"}, {31'd0, m0_err_o}, {31'd0, o.e0});
    check_eq({o.tag, ".err1"}, {31'd0, m1_err_o}, {31'd0, o.e1});
    check_eq({o.tag, ".dat0"}, m0_dat_o, o.dat);
    check_eq({o.tag, ".dat1"}, m1_dat_o, o.dat);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    //  rst q0 q1 ack err | req adr a0 a1 e0 e1
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    check_eq("reset.we", {31'd0, bus_we_o}, 32'd0);
    check_eq("reset.bsel", {28'd0, bus_bsel_o}, 32'd0);

    // Single master, ack on the second grant cycle.
    cyc(0, 1, 0, 0, 0, 0, 0,    0, 0, 0, 0, "single.idle");
    cyc(0, 1, 0, 0, 0, 1, Adr0, 0, 0, 0, 0, "single.gnt");
    check_eq("single.we", {31'd0, bus_we_o}, 32'd1);
    check_eq("single.bsel", {28'd0, bus_bsel_o}, 32'hF);
    check_eq("single.wdat", bus_dat_o, 32'hD0D0_0000);
    cyc(0, 1, 0, 1, 0, 1, Adr0, 1, 0, 0, 0, "single.ack");
    cyc(0, 0, 0, 0, 0, 0, Adr0, 0, 0, 0, 0, "single.rel");
    cyc(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "single.back_idle");

    // Tie after reset goes to m0, then m1 without an idle bubble.
    cyc(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "tie.rst");
    cyc(0, 1, 1, 0, 0, 0, 0,    0, 0, 0, 0, "tie.idle");
    cyc(0, 1, 1, 0, 0, 1, Adr0, 0, 0, 0, 0, "tie.gnt0");
    cyc(0, 1, 1, 1, 0, 1, Adr0, 1, 0, 0, 0, "tie.ack0");
    cyc(0, 0, 1, 0, 0, 0, Adr0, 0, 0, 0, 0, "tie.rel0");
    cyc(0, 0, 1, 0, 0, 1, Adr1, 0, 0, 0, 0, "tie.gnt1");
    check_eq("tie.we1", {31'd0, bus_we_o}, 32'd0);
    check_eq("tie.bsel1", {28'd0, bus_bsel_o}, 32'h3);
    cyc(0, 0, 1, 1, 0, 1, Adr1, 0, 1, 0, 0, "tie.ack1");
    cyc(0, 0, 0, 0, 0, 0, Adr1, 0, 0, 0, 0, "tie.rel1");
    cyc(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "tie.idle2");

    // 8-beat m1 refill; m0 arrives at beat 2 and must wait.
    cyc(0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, "burst.idle");
    for (int b = 1; b <= 8; b++) begin
      cyc(0, (b >= 2), 1, 1, 0, 1, Adr1, 0, 1, 0, 0, $sformatf("burst.beat%0d", b));
    end
    cyc(0, 1, 0, 0, 0, 0, Adr1, 0, 0, 0, 0, "burst.rel1");
    cyc(0, 1, 0, 0, 0, 1, Adr0, 0, 0, 0, 0, "burst.gnt0");
    cyc(0, 0, 0, 0, 0, 0, Adr0, 0, 0, 0, 0, "burst.rel0");
    cyc(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "burst.idle2");

    // Bus error during GNT0 with m1 pending.
    cyc(0, 1, 0, 0, 0, 0, 0,    0, 0, 0, 0, "err.idle");
    cyc(0, 1, 1, 0, 0, 1, Adr0, 0, 0, 0, 0, "err.gnt0");
    cyc(0, 1, 1, 0, 1, 1, Adr0, 0, 0, 1, 0, "err.err0");
    cyc(0, 1, 1, 0, 0, 0, 0,    0, 0, 0, 0, "err.idle_after");
    cyc(0, 1, 1, 0, 0, 1, Adr1, 0, 0, 0, 0, "err.gnt1");
    cyc(0, 1, 0, 0, 0, 0, Adr1, 0, 0, 0, 0, "err.rel1");
    cyc(0, 0, 0, 0, 0, 0, Adr0, 0, 0, 0, 0, "err.rel0");
    cyc(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "err.idle2");

    // m0 granted and never acked.
    cyc(0, 1, 0, 0, 0, 0, 0,    0, 0, 0, 0, "to.idle");
`ifdef MOR1KX_CACHE_ARB_TIMEOUT_EN
    for (int c = 1; c <= 3; c++) begin
      cyc(0, 1, 0, 0, 0, 1, Adr0, 0, 0, 0, 0, $sformatf("to.wait%0d", c));
    end
    cyc(0, 1, 0, 0, 0, 0, Adr0, 0, 0, 1, 0, "to.expire");
    cyc(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "to.idle_after");
`else
    for (int c = 1; c <= 20; c++) begin
      cyc(0, 1, 0, 0, 0, 1, Adr0, 0, 0, 0, 0, $sformatf("hold.cyc%0d", c));
    end
    cyc(0, 0, 0, 0, 0, 0, Adr0, 0, 0, 0, 0, "hold.rel");
    cyc(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "hold.idle");
`endif

    // Reset after the third ack of an m0 burst; following tie goes to m0.
    cyc(0, 1, 0, 0, 0, 0, 0,    0, 0, 0, 0, "rstb.idle");
    for (int b = 1; b <= 3; b++) begin
      cyc(0, 1, 0, 1, 0, 1, Adr0, 1, 0, 0, 0, $sformatf("rstb.beat%0d", b));
    end
    cyc(1, 1, 1, 0, 0, 1, Adr0, 0, 0, 0, 0, "rstb.rst");
    cyc(0, 1, 1, 1, 1, 0, 0,    0, 0, 0, 0, "rstb.idle_after");
    check_eq("rstb.we", {31'd0, bus_we_o}, 32'd0);
    cyc(0, 1, 1, 0, 0, 1, Adr0, 0, 0, 0, 0, "rstb.tie_gnt0");
    cyc(0, 0, 0, 0, 0, 0, Adr0, 0, 0, 0, 0, "rstb.rel0");
    cyc(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, "rstb.idle2");

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
